// File: rtl/bsg_source_sync_upstream_link_ctrl.sv
// bsg_source_sync_upstream_link_ctrl: bring-up sequencer and stall supervisor for one
// source-synchronous upstream channel (io reset, token override 0-1-0, link enable).
module bsg_source_sync_upstream_link_ctrl #(
    parameter int reset_cycles_p       = 16,
    parameter int token_phase_cycles_p = 8,
    parameter int post_token_cycles_p  = 8,
    parameter int enable_wait_cycles_p = 4,
    parameter int stall_timeout_p      = 1024,
    parameter int auto_retrain_p       = 1
) (
    input  logic       io_master_clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       core_valid_i,
    input  logic       core_ready_i,
    output logic       up_reset_o,
    output logic       up_link_enable_o,
    output logic       token_override_o,
    output logic       token_override_val_o,
    output logic       link_up_o,
    output logic       link_fault_o,
    output logic [7:0] retrain_count_o
);
    localparam logic [3:0] IDLE = 4'd0, IO_RST = 4'd1, TOK_LO0 = 4'd2, TOK_HI = 4'd3,
        TOK_LO1 = 4'd4, POST = 4'd5, EN_WAIT = 4'd6, UP = 4'd7, FAULT = 4'd8;
    localparam int max_a_lp = reset_cycles_p > token_phase_cycles_p ? reset_cycles_p : token_phase_cycles_p;
    localparam int max_b_lp = post_token_cycles_p > enable_wait_cycles_p ? post_token_cycles_p : enable_wait_cycles_p;
    localparam int max_dwell_lp = max_a_lp > max_b_lp ? max_a_lp : max_b_lp;
    localparam int phase_w_lp = $clog2(max_dwell_lp + 1);
    localparam int stall_w_lp = $clog2(stall_timeout_p + 1);

    logic [1:0] rst_sync;
    logic rst_n;
    logic [3:0] state_r, state_n;
    logic [phase_w_lp-1:0] phase_r;
    logic [stall_w_lp-1:0] stall_r;
    logic phase_done, stalled, timeout;
    int dwell;

    // Reset asserts asynchronously but releases two clocks after reset_n_i rises
    always_ff @(posedge io_master_clk_i or negedge reset_n_i)
        if (!reset_n_i) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    always_comb begin
        dwell = state_r == IO_RST ? reset_cycles_p :
                state_r == POST ? post_token_cycles_p :
                state_r == EN_WAIT ? enable_wait_cycles_p : token_phase_cycles_p;
        phase_done = phase_r == phase_w_lp'(dwell - 1);
        stalled = core_valid_i & ~core_ready_i;
        timeout = state_r == UP && stalled && stall_r == stall_w_lp'(stall_timeout_p - 1);
        state_n = state_r;
        case (state_r)
            IDLE:    state_n = IO_RST;
            IO_RST:  state_n = phase_done ? TOK_LO0 : IO_RST;
            TOK_LO0: state_n = phase_done ? TOK_HI : TOK_LO0;
            TOK_HI:  state_n = phase_done ? TOK_LO1 : TOK_HI;
            TOK_LO1: state_n = phase_done ? POST : TOK_LO1;
            POST:    state_n = phase_done ? EN_WAIT : POST;
            EN_WAIT: state_n = phase_done ? UP : EN_WAIT;
            UP:      state_n = timeout ? FAULT : UP;
            FAULT:   state_n = auto_retrain_p != 0 ? IO_RST : FAULT;
            default: state_n = IDLE;
        endcase
        if (!start_i) state_n = IDLE;
    end

    // Outputs decode the next state so they change on the same edge as the state
    always_ff @(posedge io_master_clk_i or negedge rst_n)
        if (!rst_n) begin
            state_r <= IDLE;
            phase_r <= '0;
            stall_r <= '0;
            link_fault_o <= 1'b0;
            retrain_count_o <= 8'd0;
            up_reset_o <= 1'b1;
            up_link_enable_o <= 1'b0;
            token_override_o <= 1'b1;
            token_override_val_o <= 1'b0;
            link_up_o <= 1'b0;
        end else begin
            state_r <= state_n;
            phase_r <= (!start_i || state_n != state_r) ? '0 : phase_r + 1'b1;
            stall_r <= (state_r == UP && state_n == UP && stalled) ? stall_r + 1'b1 : '0;
            link_fault_o <= start_i & (link_fault_o | timeout);
            retrain_count_o <= retrain_count_o +
                {7'd0, state_r == FAULT && state_n == IO_RST && retrain_count_o != 8'hff};
            up_reset_o <= state_n inside {IDLE, IO_RST, FAULT};
            up_link_enable_o <= state_n inside {EN_WAIT, UP};
            token_override_o <= !(state_n inside {EN_WAIT, UP});
            token_override_val_o <= state_n == TOK_HI;
            link_up_o <= state_n == UP;
        end
endmodule

// File: tb/tb_bsg_source_sync_upstream_link_ctrl.sv
// tb_bsg_source_sync_upstream_link_ctrl: directed bench; dut_a retrains automatically,
// dut_b does not. Both use an 8-cycle stall timeout.
module tb_bsg_source_sync_upstream_link_ctrl;
    logic clk = 1'b0;
    logic rst_a_n, start_a, valid_a, ready_a, rst_b_n, start_b, valid_b, ready_b;
    logic ur_a, en_a, ovr_a, val_a, up_a, flt_a, ur_b, en_b, ovr_b, val_b, up_b, flt_b;
    logic [7:0] cnt_a, cnt_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    bsg_source_sync_upstream_link_ctrl #(.stall_timeout_p(8), .auto_retrain_p(1)) dut_a (
        .io_master_clk_i(clk), .reset_n_i(rst_a_n), .start_i(start_a),
        .core_valid_i(valid_a), .core_ready_i(ready_a), .up_reset_o(ur_a),
        .up_link_enable_o(en_a), .token_override_o(ovr_a), .token_override_val_o(val_a),
        .link_up_o(up_a), .link_fault_o(flt_a), .retrain_count_o(cnt_a));

    bsg_source_sync_upstream_link_ctrl #(.stall_timeout_p(8), .auto_retrain_p(0)) dut_b (
        .io_master_clk_i(clk), .reset_n_i(rst_b_n), .start_i(start_b),
        .core_valid_i(valid_b), .core_ready_i(ready_b), .up_reset_o(ur_b),
        .up_link_enable_o(en_b), .token_override_o(ovr_b), .token_override_val_o(val_b),
        .link_up_o(up_b), .link_fault_o(flt_b), .retrain_count_o(cnt_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 0; rst_b_n = 0; start_a = 0; start_b = 0;
        valid_a = 0; ready_a = 0; valid_b = 0; ready_b = 0;
        repeat (3) tick();
        checks++; if ({ur_a, en_a, ovr_a, val_a, up_a, flt_a} !== 6'b101000) begin errors++; $display("FAIL reset_a_outs got %b exp 101000", {ur_a, en_a, ovr_a, val_a, up_a, flt_a}); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_a_cnt got %0d exp 0", cnt_a); end
        checks++; if ({ur_b, en_b, ovr_b, val_b, up_b, flt_b} !== 6'b101000) begin errors++; $display("FAIL reset_b_outs got %b exp 101000", {ur_b, en_b, ovr_b, val_b, up_b, flt_b}); end
        checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL reset_b_cnt got %0d exp 0", cnt_b); end
    endtask

    task automatic test_bringup();
        int t_rst = -1, t_hi = -1, t_lo1 = -1, t_ovr = -1, t_en = -1, t_up = -1, viol = 0;
        @(negedge clk);
        start_a = 1; rst_a_n = 1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (t_rst < 0 && !ur_a) t_rst = c;
            if (t_hi < 0 && val_a) t_hi = c;
            if (t_hi > 0 && t_lo1 < 0 && !val_a) t_lo1 = c;
            if (t_ovr < 0 && !ovr_a) t_ovr = c;
            if (t_en < 0 && en_a) t_en = c;
            if (t_up < 0 && up_a) t_up = c;
            if (!en_a && !ovr_a) viol++;
        end
        checks++; if (t_rst != 19) begin errors++; $display("FAIL bringup_reset_fall got %0d exp 19", t_rst); end
        checks++; if (t_hi != 27) begin errors++; $display("FAIL bringup_val_rise got %0d exp 27", t_hi); end
        checks++; if (t_lo1 != 35) begin errors++; $display("FAIL bringup_val_fall got %0d exp 35", t_lo1); end
        checks++; if (t_ovr != 51) begin errors++; $display("FAIL bringup_ovr_fall got %0d exp 51", t_ovr); end
        checks++; if (t_en != 51) begin errors++; $display("FAIL bringup_en_rise got %0d exp 51", t_en); end
        checks++; if (t_up != 55) begin errors++; $display("FAIL bringup_link_up got %0d exp 55", t_up); end
        checks++; if (viol != 0) begin errors++; $display("FAIL bringup_ovr_released_early got %0d exp 0", viol); end
    endtask

    task automatic test_stall_no_fault();
        repeat (20) tick();
        checks++; if ({up_a, flt_a} !== 2'b10) begin errors++; $display("FAIL idle_no_stall got %b exp 10", {up_a, flt_a}); end
        valid_a = 0; ready_a = 0;
        repeat (20) tick();
        checks++; if ({up_a, flt_a} !== 2'b10) begin errors++; $display("FAIL invalid_not_stall got %b exp 10", {up_a, flt_a}); end
        valid_a = 1; ready_a = 0;
        repeat (7) tick();
        ready_a = 1;
        tick();
        checks++; if ({up_a, flt_a} !== 2'b10) begin errors++; $display("FAIL stall7_no_fault got %b exp 10", {up_a, flt_a}); end
        valid_a = 0;
    endtask

    task automatic test_stall_fault();
        int c;
        valid_a = 1; ready_a = 0;
        repeat (7) tick();
        checks++; if (up_a !== 1'b1) begin errors++; $display("FAIL stall_before_timeout got %b exp 1", up_a); end
        tick();
        checks++; if ({flt_a, up_a, ur_a} !== 3'b101) begin errors++; $display("FAIL stall_fault got %b exp 101", {flt_a, up_a, ur_a}); end
        valid_a = 0;
        tick();
        checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL retrain_count got %0d exp 1", cnt_a); end
        for (c = 1; c <= 100 && !up_a; c++) tick();
        checks++; if (c - 1 != 52) begin errors++; $display("FAIL retrain_relink got %0d exp 52", c - 1); end
        checks++; if (flt_a !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", flt_a); end
    endtask

    task automatic test_no_retrain();
        int c;
        @(negedge clk);
        start_b = 1; rst_b_n = 1;
        for (c = 1; c <= 100 && !up_b; c++) tick();
        checks++; if (up_b !== 1'b1) begin errors++; $display("FAIL b_link_up got %b exp 1", up_b); end
        valid_b = 1; ready_b = 0;
        repeat (8) tick();
        checks++; if ({flt_b, up_b} !== 2'b10) begin errors++; $display("FAIL b_fault got %b exp 10", {flt_b, up_b}); end
        repeat (10) tick();
        checks++; if ({ur_b, en_b, ovr_b, flt_b, cnt_b} !== {4'b1011, 8'd0}) begin errors++; $display("FAIL b_stuck_fault got %b/%0d exp 1011/0", {ur_b, en_b, ovr_b, flt_b}, cnt_b); end
        start_b = 0; valid_b = 0;
        tick();
        checks++; if ({ur_b, flt_b, up_b} !== 3'b100) begin errors++; $display("FAIL b_idle_clear got %b exp 100", {ur_b, flt_b, up_b}); end
    endtask

    task automatic test_start_drop();
        int c;
        start_a = 0;
        tick();
        checks++; if ({flt_a, ur_a, ovr_a, en_a} !== 4'b0110) begin errors++; $display("FAIL drop_idle got %b exp 0110", {flt_a, ur_a, ovr_a, en_a}); end
        start_a = 1;
        for (c = 1; c <= 40 && !val_a; c++) tick();
        checks++; if (c - 1 != 25) begin errors++; $display("FAIL restart_val_rise got %0d exp 25", c - 1); end
        tick();
        start_a = 0;
        tick();
        checks++; if ({ur_a, val_a, ovr_a} !== 3'b101) begin errors++; $display("FAIL drop_in_hi got %b exp 101", {ur_a, val_a, ovr_a}); end
        start_a = 1;
        for (c = 1; c <= 40 && ur_a; c++) tick();
        checks++; if (c - 1 != 17) begin errors++; $display("FAIL restart_io_rst got %0d exp 17", c - 1); end
    endtask

    task automatic test_async_reset();
        int c;
        for (c = 1; c <= 60 && !en_a; c++) tick();
        checks++; if (c - 1 != 32) begin errors++; $display("FAIL en_wait_entry got %0d exp 32", c - 1); end
        tick();
        #2 rst_a_n = 0;
        #1;
        checks++; if ({ur_a, en_a, ovr_a, val_a, up_a, flt_a} !== 6'b101000) begin errors++; $display("FAIL async_reset_outs got %b exp 101000", {ur_a, en_a, ovr_a, val_a, up_a, flt_a}); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL async_reset_cnt got %0d exp 0", cnt_a); end
        rst_a_n = 1;
        for (c = 1; c <= 100 && !up_a; c++) tick();
        checks++; if (c - 1 != 55) begin errors++; $display("FAIL post_reset_link_up got %0d exp 55", c - 1); end
    endtask

    task automatic test_saturation();
        int faults = 0, viol = 0;
        logic prev_up;
        logic [7:0] prev_cnt;
        prev_up = up_a; prev_cnt = cnt_a;
        valid_a = 1; ready_a = 0;
        for (int c = 0; c < 25000 && faults < 300; c++) begin
            tick();
            if (prev_up && !up_a) faults++;
            if (cnt_a < prev_cnt) viol++;
            prev_up = up_a; prev_cnt = cnt_a;
        end
        checks++; if (faults != 300) begin errors++; $display("FAIL sat_fault_count got %0d exp 300", faults); end
        checks++; if (cnt_a !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", cnt_a); end
        repeat (3) tick();
        checks++; if (cnt_a !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", cnt_a); end
        checks++; if (viol != 0) begin errors++; $display("FAIL sat_wrap got %0d exp 0", viol); end
        valid_a = 0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_stall_no_fault();
        test_stall_fault();
        test_no_retrain();
        test_start_drop();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_source_sync_upstream_link_ctrl.md
Name: bsg_source_sync_upstream_link_ctrl

Overview:
- Bring-up and supervision sequencer for one source-synchronous upstream output channel.
- Generates the channel's io reset and link enable, and drives the token-clock override (0-1-0 pattern) required while the token counters are in reset.
- Watches the core-side handshake once the link is up. Declares a fault on a prolonged credit stall and optionally retrains.
- Sits in the io_master_clk_i domain next to the upstream channel and the token pad mux.

Parameters:
- reset_cycles_p, 16: cycles up_reset_o is held high in IO_RST (>=2).
- token_phase_cycles_p, 8: cycles per token override phase (LO0, HI, LO1) (>=2).
- post_token_cycles_p, 8: cycles in POST before enabling (>=5).
- enable_wait_cycles_p, 4: cycles in EN_WAIT before link_up_o (>=2).
- stall_timeout_p, 1024: consecutive stalled cycles that trigger a fault (>=2).
- auto_retrain_p, 1: 1 means FAULT re-enters IO_RST automatically while start_i=1.

Ports:
- io_master_clk_i  in  1  sole clock.
- reset_n_i  in  1  async active-low reset; asynchronous assert, deassert synchronized internally (2-flop).
- start_i  in  1  level; 1 requests link up, 0 forces IDLE.
- core_valid_i  in  1  observed valid into the upstream channel.
- core_ready_i  in  1  observed ready from the upstream channel.
- up_reset_o  out  1  drives channel reset_i.
- up_link_enable_o  out  1  drives channel link_enable_i.
- token_override_o  out  1  1 means the pad mux selects token_override_val_o as token_clk.
- token_override_val_o  out  1  forced token clock level.
- link_up_o  out  1  channel is usable.
- link_fault_o  out  1  sticky stall fault.
- retrain_count_o  out  8  number of FAULT->IO_RST retrains, saturating at 255.

Behaviour:
- All outputs are registered. Output values during reset: up_reset_o=1, up_link_enable_o=0, token_override_o=1, token_override_val_o=0, link_up_o=0, link_fault_o=0, retrain_count_o=0. The state register resets to IDLE.
- A single phase counter is reloaded on every state change. A state with an N-cycle dwell advances after exactly N cycles in that state.
- Outputs per state, given as (reset, en, ovr, val, up):
  - IDLE (1,0,1,0,0)
  - IO_RST (1,0,1,0,0)
  - TOK_LO0 (0,0,1,0,0)
  - TOK_HI (0,0,1,1,0)
  - TOK_LO1 (0,0,1,0,0)
  - POST (0,0,1,0,0)
  - EN_WAIT (0,1,0,0,0)
  - UP (0,1,0,0,1)
  - FAULT (1,0,1,0,0)
- Transitions:
  - IDLE goes to IO_RST when start_i=1.
  - IO_RST goes to TOK_LO0 after reset_cycles_p.
  - TOK_LO0, TOK_HI and TOK_LO1 each advance after token_phase_cycles_p.
  - POST goes to EN_WAIT after post_token_cycles_p.
  - EN_WAIT goes to UP after enable_wait_cycles_p.
  - UP goes to FAULT on timeout.
  - FAULT goes to IO_RST if auto_retrain_p=1 and start_i=1, else stays in FAULT.
- start_i=0 in any state goes to IDLE on the next edge. This has priority over every other transition, and the phase counter, stall counter and link_fault_o are cleared.
- Token override is never released while up_link_enable_o=0. The val level changes only inside the TOK_HI boundaries.
- Stall counter (width clog2(stall_timeout_p+1)) is active only in UP:
  - Increments on cycles where core_valid_i=1 and core_ready_i=0.
  - Clears on any other cycle and on leaving UP.
  - When it reaches stall_timeout_p, the next state is FAULT and link_fault_o is set in the same edge.
  - core_valid_i=0 throughout a stall is not a stall.
- link_fault_o clears only on reset_n_i or start_i=0. It stays 1 through any retrain.
- retrain_count_o increments on each FAULT->IO_RST edge. At 255 it holds.
- reset_n_i assertion mid-sequence returns all outputs to their reset values immediately (asynchronously).

Test Plan:
- Defaults, start_i=1 at cycle 0 after reset release. Required timing:
  - up_reset_o=1 for 16 cycles.
  - val=0 for 8 cycles, then 1 for 8, then 0 for 8, then ovr=0 after 8 more POST cycles.
  - en rises the same cycle ovr falls.
  - link_up_o=1 exactly 4 cycles later.
  - Total: 52 cycles after IO_RST entry.
- stall_timeout_p=8, in UP hold valid=1/ready=0 for 7 cycles then ready=1 -> no fault. Then hold 8 cycles -> link_fault_o=1, link_up_o=0, up_reset_o=1 on the next edge, retrain_count_o=1, and the sequence reruns with link_fault_o still 1.
- auto_retrain_p=0, stall to fault -> remains in FAULT with retrain_count_o=0. Then start_i=0 -> IDLE with link_fault_o=0.
- start_i dropped during TOK_HI -> next edge up_reset_o=1 and val=0. start_i reasserted -> the full sequence restarts from IO_RST with a fresh 16-cycle count.
- reset_n_i pulsed low during EN_WAIT -> outputs immediately at their reset values. After release, start_i=1 sequences normally.
- Forced 300 consecutive faults -> retrain_count_o saturates at 255, with no wrap to 0.
